// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor: gshare direction predictor (PC xor GHR indexed 2-bit counters)
// with non-speculative history training and saturating performance counters.
module gshare_branch_predictor #(
    parameter int HIST_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       i_fetch_pc,
    output logic              o_pred_taken,
    output logic [HIST_W-1:0] o_pred_history,
    input  logic              i_exe_valid,
    input  logic              i_exe_is_branch,
    input  logic [31:0]       i_exe_pc,
    input  logic [HIST_W-1:0] i_exe_history,
    input  logic              i_exe_guess,
    input  logic              i_exe_taken,
    output logic              o_exe_mispredict,
    output logic [CNT_W-1:0]  o_branch_cnt,
    output logic [CNT_W-1:0]  o_mispredict_cnt
);
    localparam int N = 1 << HIST_W;
    logic [1:0]        r_pht [N];
    logic [HIST_W-1:0] r_ghr;
    logic [CNT_W-1:0]  r_bcnt, r_mcnt;
    logic [HIST_W-1:0] w_fidx, w_uidx;
    logic [1:0]        w_ctr, w_ctr_nxt;
    logic              w_upd;
    assign w_fidx           = i_fetch_pc[HIST_W+1:2] ^ r_ghr;
    assign w_uidx           = i_exe_pc[HIST_W+1:2] ^ i_exe_history;
    assign w_upd            = i_exe_valid & i_exe_is_branch;
    assign w_ctr            = r_pht[w_uidx];
    assign w_ctr_nxt        = i_exe_taken ? (&w_ctr ? w_ctr : w_ctr + 2'd1)
                                          : (|w_ctr ? w_ctr - 2'd1 : w_ctr);
    assign o_pred_taken     = r_pht[w_fidx][1];
    assign o_pred_history   = r_ghr;
    assign o_exe_mispredict = w_upd & (i_exe_taken != i_exe_guess);
    assign o_branch_cnt     = r_bcnt;
    assign o_mispredict_cnt = r_mcnt;
    // Update index uses the history carried with the instruction, not the live GHR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) r_pht[i] <= 2'b01;
            r_ghr  <= '0;
            r_bcnt <= '0;
            r_mcnt <= '0;
        end else if (w_upd) begin
            r_pht[w_uidx] <= w_ctr_nxt;
            r_ghr         <= {r_ghr[HIST_W-2:0], i_exe_taken};
            if (~&r_bcnt) r_bcnt <= r_bcnt + CNT_W'(1);
            if (o_exe_mispredict && ~&r_mcnt) r_mcnt <= r_mcnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb_gshare_branch_predictor: scoreboard bench comparing the predictor against a reference model.
module tb_gshare_branch_predictor;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [31:0] i_fetch_pc = 0;
    logic        i_exe_valid = 0, i_exe_is_branch = 0, i_exe_guess = 0, i_exe_taken = 0;
    logic [31:0] i_exe_pc = 0;
    logic [4:0]  i_exe_history = 0;
    logic        o_pred_taken, o_exe_mispredict;
    logic [4:0]  o_pred_history;
    logic [31:0] o_branch_cnt, o_mispredict_cnt;
    logic        s_pred_taken, s_exe_mispredict;
    logic [4:0]  s_pred_history;
    logic [1:0]  s_branch_cnt, s_mispredict_cnt;
    logic [1:0]  m_pht [32];
    logic [4:0]  m_ghr;
    logic [31:0] m_b, m_m;
    int          n_cmp = 0, n_bad = 0;
    typedef struct {string tag; logic [31:0] exp;} exp_t;
    exp_t        sb[$];

    always #5 clk = ~clk;

    gshare_branch_predictor dut (
        .clk(clk), .rst_n(rst_n), .i_fetch_pc(i_fetch_pc),
        .o_pred_taken(o_pred_taken), .o_pred_history(o_pred_history),
        .i_exe_valid(i_exe_valid), .i_exe_is_branch(i_exe_is_branch), .i_exe_pc(i_exe_pc),
        .i_exe_history(i_exe_history), .i_exe_guess(i_exe_guess), .i_exe_taken(i_exe_taken),
        .o_exe_mispredict(o_exe_mispredict), .o_branch_cnt(o_branch_cnt),
        .o_mispredict_cnt(o_mispredict_cnt)
    );

    // Narrow-counter twin makes counter saturation reachable in a short run.
    gshare_branch_predictor #(.HIST_W(5), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .i_fetch_pc(i_fetch_pc),
        .o_pred_taken(s_pred_taken), .o_pred_history(s_pred_history),
        .i_exe_valid(i_exe_valid), .i_exe_is_branch(i_exe_is_branch), .i_exe_pc(i_exe_pc),
        .i_exe_history(i_exe_history), .i_exe_guess(i_exe_guess), .i_exe_taken(i_exe_taken),
        .o_exe_mispredict(s_exe_mispredict), .o_branch_cnt(s_branch_cnt),
        .o_mispredict_cnt(s_mispredict_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input string tag);
        if (tag == "pred") return {31'd0, o_pred_taken};
        if (tag == "hist") return {27'd0, o_pred_history};
        if (tag == "misp") return {31'd0, o_exe_mispredict};
        if (tag == "bcnt") return o_branch_cnt;
        if (tag == "mcnt") return o_mispredict_cnt;
        if (tag == "s_pred") return {31'd0, s_pred_taken};
        if (tag == "s_bcnt") return {30'd0, s_branch_cnt};
        if (tag == "s_mcnt") return {30'd0, s_mispredict_cnt};
        return 'x;
    endfunction

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            check(e.tag, observe(e.tag), e.exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_pht[i] = 2'b01;
        m_ghr = 0;
        m_b = 0;
        m_m = 0;
    endtask

    // Drive one cycle at the negedge; fidx selects the PHT entry fetch should read.
    task automatic step(input logic v, input logic br, input logic [31:0] epc,
                        input logic [4:0] eh, input logic g, input logic t, input logic [4:0] fidx);
        logic [4:0] u;
        @(negedge clk);
        i_fetch_pc      = ($urandom() & 32'hFFFF_FF83) | {25'd0, fidx ^ m_ghr, 2'd0};
        i_exe_valid     = v;
        i_exe_is_branch = br;
        i_exe_pc        = epc;
        i_exe_history   = eh;
        i_exe_guess     = g;
        i_exe_taken     = t;
        #1;
        push("pred", {31'd0, m_pht[fidx][1]});
        push("s_pred", {31'd0, m_pht[fidx][1]});
        push("hist", {27'd0, m_ghr});
        push("misp", {31'd0, v & br & (t != g)});
        push("bcnt", m_b);
        push("mcnt", m_m);
        push("s_bcnt", (m_b > 3) ? 32'd3 : m_b);
        push("s_mcnt", (m_m > 3) ? 32'd3 : m_m);
        drain();
        if (v && br) begin
            u = epc[6:2] ^ eh;
            if (t && m_pht[u] != 2'b11) m_pht[u] = m_pht[u] + 2'd1;
            else if (!t && m_pht[u] != 2'b00) m_pht[u] = m_pht[u] - 2'd1;
            m_ghr = {m_ghr[3:0], t};
            if (m_b != '1) m_b++;
            if (t != g && m_m != '1) m_m++;
        end
    endtask

    task automatic idle(input logic [4:0] fidx);
        step(0, 0, 0, 0, 0, 0, fidx);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        #12;
        check("rst_pred", {31'd0, o_pred_taken}, 0);
        check("rst_hist", {27'd0, o_pred_history}, 0);
        check("rst_bcnt", o_branch_cnt, 0);
        check("rst_mcnt", o_mispredict_cnt, 0);
        @(negedge clk);
        rst_n = 1;
        idle(16);
        step(1, 1, 32'h40, 0, 0, 1, 16);
        check("t2_misp", {31'd0, o_exe_mispredict}, 1);
        idle(16);
        check("t2_ghr", {27'd0, o_pred_history}, 5'b00001);
        check("t2_bcnt", o_branch_cnt, 1);
        check("t2_mcnt", o_mispredict_cnt, 1);
        check("t3_pc44", {31'd0, o_pred_taken}, 1);
        idle(17);
        check("t3_pc40", {31'd0, o_pred_taken}, 0);
        repeat (4) step(1, 1, 32'h40, 0, 1, 1, 16);
        step(1, 1, 32'h40, 0, 1, 0, 16);
        idle(16);
        check("t4_weak_taken", {31'd0, o_pred_taken}, 1);
        repeat (3) step(1, 1, 32'h40, 0, 0, 0, 16);
        idle(16);
        check("t4_zero", {31'd0, o_pred_taken}, 0);
        step(1, 1, 32'h40, 0, 0, 0, 16);
        step(1, 1, 32'h40, 0, 0, 1, 16);
        idle(16);
        check("t4_floor", {31'd0, o_pred_taken}, 0);
        step(1, 1, 32'h60, 0, 0, 1, 24);
        check("t5_same_cycle", {31'd0, o_pred_taken}, 0);
        idle(24);
        check("t5_next_cycle", {31'd0, o_pred_taken}, 1);
        step(1, 0, 32'h60, 0, 0, 1, 24);
        step(1, 0, 32'h44, 3, 1, 0, 24);
        idle(24);
        check("t6_nonbranch", {31'd0, o_pred_taken}, 1);
        repeat (60) step($urandom_range(0, 1), $urandom_range(0, 1),
                         {25'd0, 5'($urandom_range(0, 31)), 2'd0} | ($urandom() & 32'hFFFF_FF80),
                         5'($urandom_range(0, 31)), $urandom_range(0, 1), $urandom_range(0, 1),
                         5'($urandom_range(0, 31)));
        repeat (3) step(1, 1, 32'h60, 0, 0, 1, 24);
        step(1, 1, 32'h60, 0, 0, 1, 24);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check("rst_mid_pred", {31'd0, o_pred_taken}, 0);
        check("rst_mid_hist", {27'd0, o_pred_history}, 0);
        check("rst_mid_bcnt", o_branch_cnt, 0);
        check("rst_mid_mcnt", o_mispredict_cnt, 0);
        check("rst_mid_s_bcnt", {30'd0, s_branch_cnt}, 0);
        @(negedge clk);
        i_exe_valid = 0;
        rst_n = 1;
        step(1, 1, 32'h40, 0, 1, 1, 16);
        idle(16);
        check("post_rst_bcnt", o_branch_cnt, 1);
        check("post_rst_hist", {27'd0, o_pred_history}, 5'b00001);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gshare_branch_predictor.md
Name: gshare_branch_predictor

Overview:
- Direction predictor for the fetch stage. Produces the branch_guess and branch_history fields that fetch places into the fetch->decode pipeline block.
- Consumes the same fields when they return from the execute stage with the resolved outcome, and trains itself on that outcome.
- Global-history gshare scheme: a table of 2-bit saturating counters indexed by PC XOR global history register (GHR).
- Also keeps saturating performance counters for resolved branches and mispredictions.

Parameters:
- HIST_W, 5, GHR width. Also the PHT index width; the PHT has 2^HIST_W entries. Must equal the branch_history width in the pipeline blocks.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_pc  in  32  PC of the instruction being fetched.
- pred_taken  out  1  predicted direction for fetch_pc. Drives fetch_decode_block.branch_guess.
- pred_history  out  HIST_W  GHR value used to form the index. Drives fetch_decode_block.branch_history.
- exe_valid  in  1  execute stage holds a valid instruction and is advancing this cycle.
- exe_is_branch  in  1  control_word is_branch for the execute instruction.
- exe_pc  in  32  PC of the execute instruction.
- exe_history  in  HIST_W  branch_history carried down the pipe with the execute instruction.
- exe_guess  in  1  branch_guess carried down the pipe with the execute instruction.
- exe_taken  in  1  resolved br_en.
- exe_mispredict  out  1  exe_valid & exe_is_branch & (exe_taken != exe_guess). Combinational.
- branch_cnt  out  CNT_W  resolved conditional branches.
- mispredict_cnt  out  CNT_W  mispredicted conditional branches.

Behaviour:
- Reset (rst_n low, asynchronous):
  - every PHT entry = 2'b01 (weakly not-taken);
  - GHR = 0;
  - branch_cnt = 0, mispredict_cnt = 0;
  - therefore pred_taken = 0 and pred_history = 0 immediately.
  - Reset asserted mid-operation discards any in-flight update. The first edge after deassertion performs a normal update.
- Fetch index: fidx = fetch_pc[HIST_W+1:2] ^ GHR.
  - pred_taken = PHT[fidx][1].
  - pred_history = GHR.
  - Both are combinational with zero latency, so fetch samples them in the same cycle.
- Update occurs on the rising clk edge when exe_valid & exe_is_branch. No state changes otherwise, including when exe_valid=1 but exe_is_branch=0.
  - Update index: uidx = exe_pc[HIST_W+1:2] ^ exe_history. Uses the carried history, not the current GHR.
  - PHT[uidx]: increment if exe_taken, decrement otherwise. Saturates at 2'b11 and 2'b00.
  - GHR <= {GHR[HIST_W-2:0], exe_taken}. The MSB is dropped; the GHR is updated non-speculatively at resolution only.
  - branch_cnt += 1, saturating at all-ones.
  - If exe_taken != exe_guess, mispredict_cnt += 1, saturating at all-ones.
- Same-cycle read/update:
  - If fidx == uidx in the update cycle, pred_taken reflects the pre-update counter. The new value is visible from the next cycle.
  - pred_history likewise shows the pre-shift GHR in the update cycle.
- Stalls: the execute stage deasserts exe_valid while stalled, so one instruction updates exactly once.
- Flushes need no predictor action. Flushed instructions never reach execute with exe_valid=1.
- PHT storage is flops (32 x 2 bits at the default). Only one write port is required.

Test Plan:
1. Reset then release, fetch_pc=0x00000040 → pred_taken=0, pred_history=5'b00000; both counters 0.
2. Resolve exe_pc=0x40, exe_history=0, exe_guess=0, exe_taken=1, exe_valid=exe_is_branch=1 for one cycle → exe_mispredict=1 that cycle. Next cycle: GHR=5'b00001, PHT[16]=2'b10, branch_cnt=1, mispredict_cnt=1.
3. After scenario 2, fetch_pc=0x44 (index 17^1=16) → pred_taken=1, pred_history=5'b00001. fetch_pc=0x40 (index 16^1=17) → pred_taken=0.
4. Saturation at index 16 (exe_pc=0x40, exe_history=0):
   - four taken updates → PHT[16]=2'b11;
   - one not-taken → 2'b10, so prediction still taken;
   - three further not-taken → 2'b00; one more not-taken → stays 2'b00.
5. Same cycle: fetch index equals update index, counter 2'b01, update taken → pred_taken=0 that cycle, 1 the next cycle.
6. Negative and reset cases:
   - exe_valid=1 with exe_is_branch=0 → GHR, PHT and counters unchanged.
   - Drop rst_n mid-cycle after training → pred_taken and counters go to 0 before the next edge.
   - Preload branch_cnt=0xFFFFFFFF (force) and update → stays 0xFFFFFFFF.
